// File: rtl/prog_loader_pkg.sv
// Shared definitions for the configuration-chain loader: FSM encoding and a
// constant-evaluable ceil(log2) helper used to size counters and pointers.
package prog_loader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_LATCH = 2'd3
    } state_t;

    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 32'sd0;
        rem    = value - 32'sd1;
        while (rem > 32'sd0) begin
            result = result + 32'sd1;
            rem    = rem >>> 32'sd1;
        end
        return result;
    endfunction

endpackage

// File: rtl/prog_loader_if.sv
// Host-side bitstream word stream: valid/ready handshake carrying one word.
interface prog_loader_if #(
    parameter int WORD_W = 8
) ();
    logic [WORD_W-1:0] data_in;
    logic              data_valid;
    logic              data_ready;

    modport master (output data_in, output data_valid, input data_ready);
    modport slave  (input data_in, input data_valid, output data_ready);
endinterface

// File: rtl/prog_word_fifo.sv
// Synchronous word prefetch FIFO; pop_data shows the head word while not empty.
module prog_word_fifo
    import prog_loader_pkg::*;
#(
    parameter int WORD_W     = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              prog_clk,
    input  logic              prog_rst,
    input  logic              push,
    input  logic [WORD_W-1:0] push_data,
    input  logic              pop,
    output logic [WORD_W-1:0] pop_data,
    output logic              full,
    output logic              empty
);
    localparam int AW = clog2(FIFO_DEPTH);
    localparam int CW = clog2(FIFO_DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    logic [WORD_W-1:0] mem_r [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr_r;
    logic [AW-1:0]     rd_ptr_r;
    logic [CW-1:0]     count_r;
    logic              push_en_s;
    logic              pop_en_s;

    assign full      = (count_r == DEPTH_C);
    assign empty     = (count_r == CW'(0));
    assign push_en_s = push && !full;
    assign pop_en_s  = pop && !empty;
    assign pop_data  = mem_r[rd_ptr_r];

    // Word storage write port
    always_ff @(posedge prog_clk) begin
        if (push_en_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    // Pointers and occupancy; pointers wrap naturally on the power-of-two depth
    always_ff @(posedge prog_clk) begin
        if (prog_rst) begin
            wr_ptr_r <= AW'(0);
            rd_ptr_r <= AW'(0);
            count_r  <= CW'(0);
        end else begin
            if (push_en_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_en_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({push_en_s, pop_en_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end
endmodule

// File: rtl/prog_loader.sv
// Streams host bitstream words MSB-first into a TOTAL_BITS configuration chain,
// then drops prog_en to latch it; FIFO underflow pads with zeros and flags error.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int TOTAL_BITS = 1000,
    parameter int WORD_W     = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic          prog_clk,
    input  logic          prog_rst,
    input  logic          start,
    prog_loader_if.slave  host,
    output logic          prog_in,
    output logic          prog_en,
    output logic          busy,
    output logic          done,
    output logic          error
);
    localparam int CNT_W = clog2(TOTAL_BITS + 1);
    localparam int WB_W  = clog2(WORD_W);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(TOTAL_BITS - 1);
    localparam logic [WB_W-1:0]  WB_LAST  = WB_W'(WORD_W - 1);

    state_t            state_r, state_s;
    logic [WORD_W-1:0] word_r;
    logic [CNT_W-1:0]  bit_cnt_r;
    logic [WB_W-1:0]   wb_cnt_r;
    logic              uf_r;
    logic              prog_in_r, prog_en_r, busy_r, done_r, error_r;
    logic              prog_in_s, prog_en_s, busy_s, done_s, error_s;
    logic              pop_s, uf_set_s, boundary_s, last_bit_s, push_s;
    logic [WORD_W-1:0] fifo_rd_s;
    logic              fifo_full_s, fifo_empty_s;

    assign host.data_ready = !fifo_full_s;
    assign push_s          = host.data_valid && !fifo_full_s;
    assign boundary_s      = (wb_cnt_r == WB_LAST);
    assign last_bit_s      = (bit_cnt_r == LAST_BIT);

    prog_word_fifo #(
        .WORD_W     (WORD_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .prog_clk  (prog_clk),
        .prog_rst  (prog_rst),
        .push      (push_s),
        .push_data (host.data_in),
        .pop       (pop_s),
        .pop_data  (fifo_rd_s),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s)
    );

    // FSM state register
    always_ff @(posedge prog_clk) begin
        if (prog_rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE:  if (start) state_s = ST_FILL; else state_s = ST_IDLE;
            ST_FILL:  if (!fifo_empty_s) state_s = ST_SHIFT; else state_s = ST_FILL;
            ST_SHIFT: if (last_bit_s) state_s = ST_LATCH; else state_s = ST_SHIFT;
            ST_LATCH: state_s = ST_IDLE;
            default:  state_s = ST_IDLE;
        endcase
    end

    // FSM outputs: next values of the registered pins plus FIFO pop/underflow strobes
    always_comb begin
        prog_en_s = 1'b0;
        prog_in_s = 1'b0;
        busy_s    = 1'b1;
        done_s    = 1'b0;
        error_s   = error_r;
        pop_s     = 1'b0;
        uf_set_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                busy_s  = start;
                error_s = start ? 1'b0 : error_r;
            end
            ST_FILL: begin
                pop_s = !fifo_empty_s;
            end
            ST_SHIFT: begin
                prog_en_s = 1'b1;
                prog_in_s = uf_r ? 1'b0 : word_r[WORD_W-1];
                // Refill at each word boundary so the next word's MSB follows without a gap
                if (boundary_s && !last_bit_s && !uf_r) begin
                    pop_s    = !fifo_empty_s;
                    uf_set_s = fifo_empty_s;
                end else begin
                    pop_s    = 1'b0;
                    uf_set_s = 1'b0;
                end
                error_s = error_r | uf_set_s;
            end
            ST_LATCH: begin
                done_s = 1'b1;
            end
            default: begin
                busy_s = 1'b0;
            end
        endcase
    end

    // Registered output pins
    always_ff @(posedge prog_clk) begin
        if (prog_rst) begin
            prog_en_r <= 1'b0;
            prog_in_r <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            error_r   <= 1'b0;
        end else begin
            prog_en_r <= prog_en_s;
            prog_in_r <= prog_in_s;
            busy_r    <= busy_s;
            done_r    <= done_s;
            error_r   <= error_s;
        end
    end

    // Word shift register, bit counters and underflow flag
    always_ff @(posedge prog_clk) begin
        if (prog_rst) begin
            word_r    <= '0;
            bit_cnt_r <= CNT_W'(0);
            wb_cnt_r  <= WB_W'(0);
            uf_r      <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        uf_r <= 1'b0;
                    end
                end
                ST_FILL: begin
                    word_r    <= fifo_rd_s;
                    bit_cnt_r <= CNT_W'(0);
                    wb_cnt_r  <= WB_W'(0);
                end
                ST_SHIFT: begin
                    bit_cnt_r <= bit_cnt_r + CNT_W'(1);
                    if (boundary_s) begin
                        wb_cnt_r <= WB_W'(0);
                        word_r   <= pop_s ? fifo_rd_s : {word_r[WORD_W-2:0], 1'b0};
                    end else begin
                        wb_cnt_r <= wb_cnt_r + WB_W'(1);
                        word_r   <= {word_r[WORD_W-2:0], 1'b0};
                    end
                    if (uf_set_s) begin
                        uf_r <= 1'b1;
                    end
                end
                default: begin
                    word_r <= word_r;
                end
            endcase
        end
    end

    assign prog_in = prog_in_r;
    assign prog_en = prog_en_r;
    assign busy    = busy_r;
    assign done    = done_r;
    assign error   = error_r;
endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 Parameter TOTAL_BITS, default 1000, length of the downstream configuration shift chain in bits (>=2).
REQ-002 Parameter WORD_W, default 8, width of each bitstream word accepted from the host (>=2).
REQ-003 Parameter FIFO_DEPTH, default 4, word prefetch depth (power of two, >=2).
REQ-004 prog_clk  input  1  single clock; all logic on posedge; also clocks the downstream chain.
REQ-005 prog_rst  input  1  synchronous, active-high reset.
REQ-006 start  input  1  one-cycle pulse requesting a full chain load.
REQ-007 data_in  input  WORD_W  bitstream word, MSB shifted first.
REQ-008 data_valid  input  1  data_in valid.
REQ-009 data_ready  output  1  word accepted when data_valid && data_ready at posedge.
REQ-010 prog_in  output  1  serial bit to the first chain stage.
REQ-011 prog_en  output  1  shift enable to the chain; its falling edge latches the chain.
REQ-012 busy  output  1  high from start acceptance until the cycle after the latch.
REQ-013 done  output  1  one-cycle pulse at load completion.
REQ-014 error  output  1  sticky underflow flag.

Function
REQ-015 Shall implement FSM states IDLE, FILL, SHIFT, LATCH.
REQ-016 IDLE: start -> FILL, busy=1, error cleared; start in any other state shall be ignored.
REQ-017 FILL: shall wait until the FIFO holds >=1 word, then pop it into the word register and enter SHIFT.
REQ-018 prog_in and prog_en shall be registered and change on the same posedge.
REQ-019 SHIFT: prog_en=1 for exactly TOTAL_BITS consecutive cycles, one new bit on prog_in per cycle, MSB of each word first, first popped word first.
REQ-020 A bit counter of width clog2(TOTAL_BITS+1) shall count bits; a new word shall be popped on every WORD_W-bit boundary, with no bubble between words.
REQ-021 Words required per load = ceil(TOTAL_BITS/WORD_W); unused low bits of the final word shall be discarded.
REQ-022 Underflow: if the FIFO is empty at a word boundary, error shall set, all remaining bits shall be 0, and no further pops shall occur in that load; prog_en shall not drop early.
REQ-023 After the last bit, LATCH: prog_en=0, prog_in=0, done=1 for one cycle, then IDLE with busy=0.
REQ-024 data_ready = FIFO not full, in every state including IDLE (prefetch allowed); words left after a load shall remain for the next load.
REQ-025 Simultaneous push and pop on a full FIFO shall be blocked (data_ready=0); on a non-full FIFO both shall take effect.
REQ-026 prog_in shall be 0 whenever prog_en=0.

Reset
REQ-027 On prog_rst: state=IDLE; prog_en, prog_in, busy, done, error = 0; FIFO emptied; data_ready=1 the following cycle.
REQ-028 Reset during SHIFT shall drop prog_en, accepting that the chain latches partial content; no done pulse shall be issued.

Structure
REQ-029 A shared package shall hold the FSM state encoding and a clog2 helper.
REQ-030 The word FIFO shall be a sub-module prog_word_fifo (synchronous, parameters WORD_W, FIFO_DEPTH; push/pop/full/empty).

Verification (TOTAL_BITS=20, WORD_W=8, chain = 20-bit config shift register)
REQ-031 Prefetch 0xA5, 0x3C, 0xF0, pulse start -> prog_en high exactly 20 cycles; chain control = 0xA53CF; done one pulse; error=0.
REQ-032 Push only 0xA5, 0x3C, then start -> control = 0xA53C0, error=1, done pulses; error clears on next start.
REQ-033 start with empty FIFO, words pushed 5 cycles later with data_valid toggling -> FSM holds in FILL with prog_en=0; final control = 0xA53CF.
REQ-034 Push 5 words with no start -> data_ready=0 after 4; 5th accepted only after a pop.
REQ-035 prog_rst asserted at SHIFT bit 7 -> next cycle prog_en=0, busy=0, done never pulses, FIFO empty.
REQ-036 start pulses during SHIFT -> ignored; exactly 20 prog_en cycles and one done.
